// File: rtl/instr_prefetch_queue_if.sv
// Fetch front-end bundle: instruction memory read port, decode port, branch redirect and status.
// master = the prefetch queue, slave = memory/decode/execute side.
interface instr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic          ir_valid;
  logic [15:0]   ir;
  logic [15:0]   ir_pc;
  logic          ir_ready;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic          halted;
  logic [CW-1:0] count;

  modport master (
    output mem_req, mem_addr, ir_valid, ir, ir_pc, halted, count,
    input  mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir, ir_pc, halted, count,
    output mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: one-outstanding word fetcher feeding a small {instr, pc} FIFO,
// flushed by branch redirect and parked after fetching the halt word 16'hFFFF.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                  clock,
  input  logic                  reset,
  instr_prefetch_queue_if.master bus
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam int            PW        = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [15:0]   HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        r_state;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_mem_addr;
  logic          r_mem_req;
  logic          r_discard;
  logic          r_halted;

  logic [15:0]   r_ir_mem [DEPTH];
  logic [15:0]   r_pc_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [15:0]   w_redirect_pc;

  assign w_ack         = (r_state == S_REQ) && bus.mem_ack;
  assign w_push        = w_ack && !r_discard && !bus.redirect;
  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && bus.ir_ready && !bus.redirect;
  assign w_redirect_pc = bus.redirect_pc & 16'hFFFE;

  // Fetch control. Redirect overrides everything; an in-flight request cannot be
  // withdrawn, so it is marked for discard and its eventual ack is swallowed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_discard  <= 1'b0;
      r_halted   <= 1'b0;
    end else if (bus.redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_halted   <= 1'b0;
      if ((r_state == S_REQ) && !bus.mem_ack) begin
        r_discard <= 1'b1;
      end else begin
        r_state   <= S_IDLE;
        r_mem_req <= 1'b0;
        r_discard <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count < FULL) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_discard <= 1'b0;
            if (!r_discard && (bus.mem_rdata == HALT_WORD)) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
            end
            if (!r_discard) begin
              r_fetch_pc <= r_fetch_pc + 16'd2;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_ir_mem[r_wr_ptr] <= bus.mem_rdata;
      r_pc_mem[r_wr_ptr] <= r_mem_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked when empty so ir/ir_pc read zero out of reset without clearing storage.
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.ir_valid = w_valid;
  assign bus.ir       = w_valid ? r_ir_mem[r_rd_ptr] : 16'h0000;
  assign bus.ir_pc    = w_valid ? r_pc_mem[r_rd_ptr] : 16'h0000;
  assign bus.halted   = r_halted;
  assign bus.count    = r_count;

  a_count_bound: assert property (@(posedge clock) disable iff (reset) r_count <= FULL);
  a_addr_even:   assert property (@(posedge clock) disable iff (reset) r_mem_addr[0] == 1'b0);

endmodule
